matvec_host: RTL and testbench

MATVEC_HOST -- requirements
Module: matvec_host

---
 rtl/matvec_host_if.sv | 31 +++
 rtl/matvec_host.sv | 139 +++++++++++++
 tb/tb_matvec_host.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/matvec_host_if.sv
// Signal bundle for matvec_host: buffer load port, transfer control,
// multiplier element/result streams and the combinational result read port.
interface matvec_host_if #(
  parameter int DW = 14,
  parameter int OW = 28
);
  logic          load_en;
  logic [3:0]    load_addr;
  logic [DW-1:0] load_data;
  logic          start;
  logic          busy;
  logic          done;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          r_valid;
  logic [OW-1:0] r_data;
  logic          r_ready;
  logic [1:0]    res_addr;
  logic [OW-1:0] res_data;

  modport master (
    output load_en, load_addr, load_data, start, m_ready, r_valid, r_data, res_addr,
    input  busy, done, m_valid, m_data, r_ready, res_data
  );

  modport slave (
    input  load_en, load_addr, load_data, start, m_ready, r_valid, r_data, res_addr,
    output busy, done, m_valid, m_data, r_ready, res_data
  );
endinterface

// File: rtl/matvec_host.sv
// Host-side sequencer for an external matrix-vector multiplier: streams S*S weights
// then S vector elements, collects S results. Optional MATVEC_HOST_SAT_CHECK_EN adds sat_flag.
module matvec_host #(
  parameter int S  = 3,
  parameter int DW = 14,
  parameter int OW = 28
) (
  input  logic           clk,
  input  logic           reset,
  matvec_host_if.slave   bus
`ifdef MATVEC_HOST_SAT_CHECK_EN
  ,
  output logic [S-1:0]   sat_flag
`endif
);

  localparam int N  = S * S + S;
  localparam int CW = $clog2(N);
  localparam int RW = (S > 1) ? $clog2(S) : 1;
  localparam logic [CW-1:0] SEND_LAST  = CW'(N - 1);
  localparam logic [RW-1:0] RES_LAST   = RW'(S - 1);
  localparam logic [4:0]    ADDR_LIMIT = 5'(N);

  typedef enum logic [1:0] {IDLE, SEND, COLLECT, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] sendCnt_q, sendCnt_d;
  logic [RW-1:0] resCnt_q, resCnt_d;
  logic [DW-1:0] elemBuf_q [N];
  logic [OW-1:0] res_q [S];

  logic startAccept;
  logic loadWe;
  logic resWe;

  assign startAccept = (state_q == IDLE) && bus.start;
  assign loadWe      = (state_q == IDLE) && bus.load_en && ({1'b0, bus.load_addr} < ADDR_LIMIT);
  assign resWe       = (state_q == COLLECT) && bus.r_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sendCnt_q <= '0;
      resCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      sendCnt_q <= sendCnt_d;
      resCnt_q  <= resCnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sendCnt_d   = sendCnt_q;
    resCnt_d    = resCnt_q;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.m_valid = 1'b0;
    bus.r_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (startAccept) begin
          state_d   = SEND;
          sendCnt_d = '0;
        end
      end
      SEND: begin
        bus.busy    = 1'b1;
        bus.m_valid = 1'b1;
        if (bus.m_ready) begin
          if (sendCnt_q == SEND_LAST) begin
            state_d  = COLLECT;
            resCnt_d = '0;
          end else begin
            sendCnt_d = sendCnt_q + CW'(1);
          end
        end
      end
      COLLECT: begin
        bus.busy    = 1'b1;
        bus.r_ready = 1'b1;
        if (bus.r_valid) begin
          if (resCnt_q == RES_LAST) begin
            state_d = DONE;
          end else begin
            resCnt_d = resCnt_q + RW'(1);
          end
        end
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The buffer only changes in IDLE, so m_data is stable while a SEND element stalls.
  assign bus.m_data = (state_q == SEND) ? elemBuf_q[sendCnt_q] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) elemBuf_q[i] <= '0;
    end else if (loadWe) begin
      elemBuf_q[bus.load_addr[CW-1:0]] <= bus.load_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < S; i++) res_q[i] <= '0;
    end else if (resWe) begin
      res_q[resCnt_q] <= bus.r_data;
    end
  end

  assign bus.res_data = ({30'b0, bus.res_addr} < 32'(S)) ? res_q[bus.res_addr[RW-1:0]] : '0;

`ifdef MATVEC_HOST_SAT_CHECK_EN
  localparam logic [OW-1:0] RES_MAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] RES_MIN = {1'b1, {(OW-1){1'b0}}};

  logic [S-1:0] satFlag_q;

  // A flag marks a result that landed exactly on a signed rail, i.e. likely clipped upstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      satFlag_q <= '0;
    end else if (startAccept) begin
      satFlag_q <= '0;
    end else if (resWe && ((bus.r_data == RES_MAX) || (bus.r_data == RES_MIN))) begin
      satFlag_q[resCnt_q] <= 1'b1;
    end
  end

  assign sat_flag = satFlag_q;
`endif

endmodule

// File: tb/tb_matvec_host.sv
// Directed, table-driven bench for matvec_host; the bench also acts as the
// saturating multiplier that consumes elements and returns results.
module tb_matvec_host;

  localparam int S  = 3;
  localparam int DW = 14;
  localparam int OW = 28;
  localparam int N  = S * S + S;

  logic clk = 1'b0;
  logic reset;

  matvec_host_if #(.DW(DW), .OW(OW)) bus ();

`ifdef MATVEC_HOST_SAT_CHECK_EN
  logic [S-1:0] satFlag;
`endif

  matvec_host #(.S(S), .DW(DW), .OW(OW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
`ifdef MATVEC_HOST_SAT_CHECK_EN
    ,
    .sat_flag(satFlag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0][DW-1:0] w;
    logic [2:0][DW-1:0] x;
    logic               doLoad;
    logic               toggleReady;
    logic               disturb;
    logic [2:0][OW-1:0] expRes;
    logic [2:0]         expSat;
  } vec_t;

  vec_t          vecs [6];
  logic [DW-1:0] bufModel [N];
  int            checkCount = 0;
  int            passCount  = 0;

  function automatic logic [8:0][DW-1:0] mat(int a0, int a1, int a2, int a3, int a4,
                                             int a5, int a6, int a7, int a8);
    mat[0] = DW'(a0); mat[1] = DW'(a1); mat[2] = DW'(a2);
    mat[3] = DW'(a3); mat[4] = DW'(a4); mat[5] = DW'(a5);
    mat[6] = DW'(a6); mat[7] = DW'(a7); mat[8] = DW'(a8);
  endfunction

  function automatic logic [2:0][DW-1:0] vec3(int a, int b, int c);
    vec3[0] = DW'(a); vec3[1] = DW'(b); vec3[2] = DW'(c);
  endfunction

  function automatic logic [2:0][OW-1:0] res3(int a, int b, int c);
    res3[0] = OW'(a); res3[1] = OW'(b); res3[2] = OW'(c);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic writeElem(input int addr, input logic [DW-1:0] data);
    bus.load_en   = 1'b1;
    bus.load_addr = 4'(addr);
    bus.load_data = data;
    @(negedge clk);
    bus.load_en   = 1'b0;
  endtask

  task automatic loadOperands(input vec_t v);
    for (int j = 0; j < 9; j++) begin
      writeElem(j, v.w[j]);
      bufModel[j] = v.w[j];
    end
    for (int j = 0; j < 3; j++) begin
      writeElem(9 + j, v.x[j]);
      bufModel[9 + j] = v.x[j];
    end
    writeElem(12, DW'(16'h0ABC));
    writeElem(15, DW'(16'h0DEF));
  endtask

  // Runs one transfer from the current negedge, playing the multiplier role.
  task automatic applyStimulus(input vec_t v, input string tag);
    logic [DW-1:0] got [$];
    logic [OW-1:0] mulRes [S];
    logic [DW-1:0] prevData;
    longint        acc;
    int            k, doneSeen;
    bit            prevStall, finished;
    got.delete();
    k = 0; doneSeen = 0; prevStall = 1'b0; finished = 1'b0; prevData = '0;
    for (int i = 0; i < S; i++) mulRes[i] = '0;
    bus.m_ready = 1'b1;
    bus.r_valid = 1'b1;
    bus.r_data  = '0;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      if (v.toggleReady) bus.m_ready = (cyc % 2 == 1);
      if (v.disturb && cyc == 3) begin
        bus.start = 1'b1; bus.load_en = 1'b1; bus.load_addr = 4'd11; bus.load_data = DW'(16'h1555);
      end else begin
        bus.start = 1'b0; bus.load_en = 1'b0;
      end
      if (prevStall && bus.m_valid) checkOutput({tag, " stall hold"}, 64'(bus.m_data), 64'(prevData));
      prevStall = bus.m_valid && !bus.m_ready;
      prevData  = bus.m_data;
      if (bus.m_valid && bus.m_ready) begin
        got.push_back(bus.m_data);
        if (got.size() == N) begin
          for (int i = 0; i < S; i++) begin
            acc = 0;
            for (int j = 0; j < S; j++)
              acc += longint'($signed(got[i*S + j])) * longint'($signed(got[S*S + j]));
            if (acc > 134217727) acc = 134217727;
            if (acc < -134217728) acc = -134217728;
            mulRes[i] = OW'(acc);
          end
        end
      end
      bus.r_data = (k < S) ? mulRes[k] : '0;
      if (bus.r_ready) k++;
      if (bus.done) doneSeen++;
      else if (doneSeen > 0) finished = 1'b1;
      @(negedge clk);
    end
    bus.start = 1'b0; bus.load_en = 1'b0; bus.r_valid = 1'b0; bus.m_ready = 1'b0;
    checkOutput({tag, " finished"}, 64'(finished), 64'(1));
    checkOutput({tag, " done count"}, 64'(doneSeen), 64'(1));
    checkOutput({tag, " elem count"}, 64'(got.size()), 64'(N));
    for (int j = 0; j < N && j < got.size(); j++)
      checkOutput($sformatf("%s elem%0d", tag, j), 64'(got[j]), 64'(bufModel[j]));
    checkOutput({tag, " busy idle"}, 64'(bus.busy), 64'(0));
    checkOutput({tag, " m_valid idle"}, 64'(bus.m_valid), 64'(0));
    for (int i = 0; i < S; i++) begin
      bus.res_addr = 2'(i);
      #1;
      checkOutput($sformatf("%s res%0d", tag, i), 64'(bus.res_data), 64'(v.expRes[i]));
    end
`ifdef MATVEC_HOST_SAT_CHECK_EN
    checkOutput({tag, " sat_flag"}, 64'(satFlag), 64'(v.expSat));
`endif
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t z;
    int   hs, cyc, doneSeen;

    vecs[0] = '{w: mat(1,0,0, 0,1,0, 0,0,1), x: vec3(1,2,3), doLoad: 1, toggleReady: 0,
                disturb: 0, expRes: res3(1,2,3), expSat: 3'b000};
    vecs[1] = '{w: mat(1,2,3, 4,5,6, 7,8,9), x: vec3(1,-1,2), doLoad: 1, toggleReady: 1,
                disturb: 0, expRes: res3(5,11,17), expSat: 3'b000};
    vecs[2] = '{w: mat(8191,8191,8191, 8191,8191,8191, 8191,8191,8191), x: vec3(8191,8191,8191),
                doLoad: 1, toggleReady: 0, disturb: 0,
                expRes: res3(134217727,134217727,134217727), expSat: 3'b111};
    vecs[3] = '{w: mat(-8192,-8192,-8192, -8192,-8192,-8192, -8192,-8192,-8192), x: vec3(8191,8191,8191),
                doLoad: 1, toggleReady: 1, disturb: 0,
                expRes: res3(-134217728,-134217728,-134217728), expSat: 3'b111};
    vecs[4] = '{w: mat(2,0,-1, 0,3,0, -4,1,1), x: vec3(5,6,7), doLoad: 1, toggleReady: 1,
                disturb: 1, expRes: res3(3,18,-7), expSat: 3'b000};
    vecs[5] = '{w: mat(2,0,-1, 0,3,0, -4,1,1), x: vec3(5,6,7), doLoad: 0, toggleReady: 0,
                disturb: 0, expRes: res3(3,18,-7), expSat: 3'b000};

    reset = 1'b1;
    bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0; bus.start = 1'b0;
    bus.m_ready = 1'b0; bus.r_valid = 1'b0; bus.r_data = '0; bus.res_addr = '0;
    for (int j = 0; j < N; j++) bufModel[j] = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset busy", 64'(bus.busy), 64'(0));
    checkOutput("reset done", 64'(bus.done), 64'(0));
    checkOutput("reset m_valid", 64'(bus.m_valid), 64'(0));
    checkOutput("reset r_ready", 64'(bus.r_ready), 64'(0));
    checkOutput("reset m_data", 64'(bus.m_data), 64'(0));
    for (int i = 0; i < S; i++) begin
      bus.res_addr = 2'(i);
      #1;
      checkOutput($sformatf("reset res%0d", i), 64'(bus.res_data), 64'(0));
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].doLoad) loadOperands(vecs[i]);
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Abandon a transfer with reset after five element handshakes.
    loadOperands(vecs[1]);
    bus.m_ready = 1'b1; bus.r_valid = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    hs = 0; cyc = 0;
    while (hs < 5 && cyc < 50) begin
      if (bus.m_valid && bus.m_ready) hs++;
      @(negedge clk);
      cyc++;
    end
    checkOutput("midsend handshakes", 64'(hs), 64'(5));
    checkOutput("midsend busy", 64'(bus.busy), 64'(1));
    #2 reset = 1'b1;
    #1;
    checkOutput("async reset m_valid", 64'(bus.m_valid), 64'(0));
    checkOutput("async reset busy", 64'(bus.busy), 64'(0));
    checkOutput("async reset m_data", 64'(bus.m_data), 64'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < N; j++) bufModel[j] = '0;
    for (int i = 0; i < S; i++) begin
      bus.res_addr = 2'(i);
      #1;
      checkOutput($sformatf("post reset res%0d", i), 64'(bus.res_data), 64'(0));
    end
`ifdef MATVEC_HOST_SAT_CHECK_EN
    checkOutput("post reset sat_flag", 64'(satFlag), 64'(0));
`endif
    doneSeen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.done) doneSeen++;
    end
    checkOutput("post reset no done", 64'(doneSeen), 64'(0));
    checkOutput("post reset busy", 64'(bus.busy), 64'(0));

    z = '0;
    applyStimulus(z, "zero buffer");
    loadOperands(vecs[0]);
    applyStimulus(vecs[0], "reload");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
